// File: rtl/alarm_pkg.sv
// Shared state encodings and default timing constants for the alarm ring sequencer.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } state_e;

   localparam int unsigned DEF_CLK_HZ         = 100000000;
   localparam int unsigned DEF_RING_SECONDS   = 60;
   localparam int unsigned DEF_SNOOZE_SECONDS = 300;
   localparam int unsigned DEF_MAX_SNOOZE     = 3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Cycle/second counter with synchronous clear; tick marks the last cycle of each second.
module sec_tick_gen #(
   parameter int unsigned CLK_HZ  = 10,
   parameter int unsigned SEC_MAX = 4,
   parameter int unsigned SEC_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             tick,
   output logic [SEC_W-1:0] sec
);

   localparam int unsigned      CYC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(SEC_MAX);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [SEC_W-1:0] sec_q, sec_d;

   assign tick = (cyc_q == CYC_LAST);
   assign sec  = sec_q;

   always_comb begin
      cyc_d = tick ? '0 : cyc_q + 1'b1;
      sec_d = sec_q;
      // Seconds saturate so the counter can idle indefinitely without wrapping.
      if (tick && (sec_q != SEC_TOP)) begin
         sec_d = sec_q + 1'b1;
      end
      if (clr) begin
         cyc_d = '0;
         sec_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         sec_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         sec_q <= sec_d;
      end
   end

endmodule

// File: rtl/alarm_ring_sequencer.sv
// Alarm ringing FSM: ring on alarm_match rising edge, snooze up to MAX_SNOOZE times, auto-stop on timeout.
module alarm_ring_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
   parameter int unsigned RING_SECONDS   = DEF_RING_SECONDS,
   parameter int unsigned SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
   parameter int unsigned MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alarm_armed,
   input  logic       alarm_match,
   input  logic       snooze_btn,
   input  logic       dismiss_btn,
   output logic       led_enable,
   output logic       buzzer_en,
   output logic       snooze_active,
   output logic [2:0] snooze_cnt,
   output logic       missed,
   output logic [1:0] state
);

   localparam int unsigned      SEC_SAT   = max_u(RING_SECONDS, SNOOZE_SECONDS);
   localparam int unsigned      SEC_W     = $clog2(SEC_SAT + 1);
   localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SECONDS - 1);
   localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_SECONDS - 1);
   localparam logic [2:0]       SNZ_LIMIT = 3'(MAX_SNOOZE);

   state_e           state_q, state_d;
   logic [2:0]       snz_cnt_q, snz_cnt_d;
   logic             missed_q, missed_d;
   logic             match_prev_q;
   logic             led_q, buz_q, snz_act_q;
   logic             match_rise;
   logic             cnt_clr;
   logic             sec_tick;
   logic [SEC_W-1:0] sec_cnt;
   logic             ring_done, snz_done;

   assign match_rise = alarm_match & ~match_prev_q;
   assign cnt_clr    = (state_d != state_q);

   sec_tick_gen #(
      .CLK_HZ (CLK_HZ),
      .SEC_MAX(SEC_SAT),
      .SEC_W  (SEC_W)
   ) u_sec_tick_gen (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .tick(sec_tick),
      .sec (sec_cnt)
   );

   // Firing on the last cycle of the final second lands the transition exactly N seconds after entry.
   assign ring_done = sec_tick && (sec_cnt == RING_LAST);
   assign snz_done  = sec_tick && (sec_cnt == SNZ_LAST);

   always_comb begin
      state_d   = state_q;
      snz_cnt_d = snz_cnt_q;
      missed_d  = missed_q;
      case (state_q)
         ST_IDLE: begin
            if (!alarm_armed) begin
               state_d = ST_IDLE;
            end else if (dismiss_btn) begin
               missed_d = 1'b0;
            end else if (match_rise) begin
               state_d   = ST_RINGING;
               snz_cnt_d = '0;
               missed_d  = 1'b0;
            end
         end
         ST_RINGING: begin
            if (!alarm_armed || dismiss_btn) begin
               state_d = ST_IDLE;
            end else if (snooze_btn && (snz_cnt_q < SNZ_LIMIT)) begin
               state_d   = ST_SNOOZE;
               snz_cnt_d = snz_cnt_q + 3'd1;
            end else if (ring_done) begin
               state_d  = ST_IDLE;
               missed_d = 1'b1;
            end
         end
         ST_SNOOZE: begin
            if (!alarm_armed || dismiss_btn) begin
               state_d = ST_IDLE;
            end else if (snz_done) begin
               state_d = ST_RINGING;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         snz_cnt_q    <= '0;
         missed_q     <= 1'b0;
         match_prev_q <= 1'b0;
         led_q        <= 1'b0;
         buz_q        <= 1'b0;
         snz_act_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         snz_cnt_q    <= snz_cnt_d;
         missed_q     <= missed_d;
         match_prev_q <= alarm_match;
         led_q        <= (state_d == ST_RINGING);
         buz_q        <= (state_d == ST_RINGING);
         snz_act_q    <= (state_d == ST_SNOOZE);
      end
   end

   assign led_enable    = led_q;
   assign buzzer_en     = buz_q;
   assign snooze_active = snz_act_q;
   assign snooze_cnt    = snz_cnt_q;
   assign missed        = missed_q;
   assign state         = state_q;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Scoreboard bench for alarm_ring_sequencer with CLK_HZ=10, RING_SECONDS=4, SNOOZE_SECONDS=3, MAX_SNOOZE=2.
module tb_alarm_ring_sequencer;

   typedef struct packed {
      logic [1:0] st;
      logic       led;
      logic       buz;
      logic       snz;
      logic [2:0] cnt;
      logic       mis;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alarm_armed = 1'b0;
   logic       alarm_match = 1'b0;
   logic       snooze_btn = 1'b0;
   logic       dismiss_btn = 1'b0;
   logic       led_enable, buzzer_en, snooze_active, missed;
   logic [2:0] snooze_cnt;
   logic [1:0] state;

   exp_t sb[$];
   exp_t e, o;
   int   n_run = 0;
   int   n_fail = 0;

   alarm_ring_sequencer #(
      .CLK_HZ        (10),
      .RING_SECONDS  (4),
      .SNOOZE_SECONDS(3),
      .MAX_SNOOZE    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alarm_armed  (alarm_armed),
      .alarm_match  (alarm_match),
      .snooze_btn   (snooze_btn),
      .dismiss_btn  (dismiss_btn),
      .led_enable   (led_enable),
      .buzzer_en    (buzzer_en),
      .snooze_active(snooze_active),
      .snooze_cnt   (snooze_cnt),
      .missed       (missed),
      .state        (state)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [1:0] st, input logic [2:0] cnt, input logic mis);
      exp_t r;
      r.st  = st;
      r.led = (st == 2'd1);
      r.buz = (st == 2'd1);
      r.snz = (st == 2'd2);
      r.cnt = cnt;
      r.mis = mis;
      return r;
   endfunction

   function automatic exp_t obs();
      return {state, led_enable, buzzer_en, snooze_active, snooze_cnt, missed};
   endfunction

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sb.push_back(mk(2'd0, 3'd0, 1'b0));
      tick(2);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL reset_state: got %b want %b", o, e); end
      rst = 1'b0;
      alarm_armed = 1'b1;
      tick(3);
   endtask

   task automatic test_timeout();
      alarm_match = 1'b1;
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL ring_entry: got %b want %b", o, e); end
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick(39);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL ring_before_timeout: got %b want %b", o, e); end
      sb.push_back(mk(2'd0, 3'd0, 1'b1));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL ring_timeout: got %b want %b", o, e); end
      sb.push_back(mk(2'd0, 3'd0, 1'b1));
      tick(100);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL match_level_no_retrigger: got %b want %b", o, e); end
      dismiss_btn = 1'b1;
      sb.push_back(mk(2'd0, 3'd0, 1'b0));
      tick();
      dismiss_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL idle_dismiss_clears_missed: got %b want %b", o, e); end
      alarm_match = 1'b0;
      tick(2);
   endtask

   task automatic test_snooze();
      alarm_match = 1'b1;
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_ring_entry: got %b want %b", o, e); end
      tick(5);
      snooze_btn = 1'b1;
      sb.push_back(mk(2'd2, 3'd1, 1'b0));
      tick();
      snooze_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_enter: got %b want %b", o, e); end
      sb.push_back(mk(2'd2, 3'd1, 1'b0));
      tick(29);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_before_expiry: got %b want %b", o, e); end
      sb.push_back(mk(2'd1, 3'd1, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_expiry_rings: got %b want %b", o, e); end
   endtask

   task automatic test_snooze_limit();
      snooze_btn = 1'b1;
      sb.push_back(mk(2'd2, 3'd2, 1'b0));
      tick();
      snooze_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL second_snooze: got %b want %b", o, e); end
      sb.push_back(mk(2'd1, 3'd2, 1'b0));
      tick(30);
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL second_snooze_expiry: got %b want %b", o, e); end
      snooze_btn = 1'b1;
      sb.push_back(mk(2'd1, 3'd2, 1'b0));
      tick();
      snooze_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_limit_ignored: got %b want %b", o, e); end
   endtask

   task automatic test_snooze_dismiss_same_cycle();
      snooze_btn  = 1'b1;
      dismiss_btn = 1'b1;
      sb.push_back(mk(2'd0, 3'd2, 1'b0));
      tick();
      snooze_btn  = 1'b0;
      dismiss_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL dismiss_beats_snooze: got %b want %b", o, e); end
      alarm_match = 1'b0;
      tick(2);
   endtask

   task automatic test_disarm();
      alarm_match = 1'b1;
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL disarm_ring_entry: got %b want %b", o, e); end
      snooze_btn = 1'b1;
      tick();
      snooze_btn  = 1'b0;
      alarm_armed = 1'b0;
      sb.push_back(mk(2'd0, 3'd1, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL disarm_in_snooze: got %b want %b", o, e); end
      alarm_armed = 1'b1;
      alarm_match = 1'b0;
      tick(2);
   endtask

   task automatic test_async_reset();
      alarm_match = 1'b1;
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL rst_ring_entry: got %b want %b", o, e); end
      tick(4);
      #2 rst = 1'b1;
      sb.push_back(mk(2'd0, 3'd0, 1'b0));
      #1;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL async_reset_mid_ring: got %b want %b", o, e); end
      #1 rst = 1'b0;
      sb.push_back(mk(2'd1, 3'd0, 1'b0));
      tick();
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL edge_after_reset: got %b want %b", o, e); end
      dismiss_btn = 1'b1;
      sb.push_back(mk(2'd0, 3'd0, 1'b0));
      tick();
      dismiss_btn = 1'b0;
      e = sb.pop_front(); o = obs(); n_run++;
      if (o !== e) begin n_fail++; $display("FAIL dismiss_ringing: got %b want %b", o, e); end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_snooze();
      test_snooze_limit();
      test_snooze_dismiss_same_cycle();
      test_disarm();
      test_async_reset();
      if (sb.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_ring_sequencer.md
ALARM_RING_SEQUENCER -- requirements
Module: alarm_ring_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clk cycles per second.
REQ-002 Parameter RING_SECONDS, default 60: max ringing time before auto-stop.
REQ-003 Parameter SNOOZE_SECONDS, default 300: snooze duration.
REQ-004 Parameter MAX_SNOOZE, default 3, range 1-7: snoozes allowed per alarm event.
REQ-005 Port clk  in  1  system clock, rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port alarm_armed  in  1  alarm enabled (level).
REQ-008 Port alarm_match  in  1  time==alarm time (level, may stay high for a full minute).
REQ-009 Port snooze_btn  in  1  debounced single-cycle pulse.
REQ-010 Port dismiss_btn  in  1  debounced single-cycle pulse.
REQ-011 Port led_enable  out  1  drives the alarm RGB LED block's enable.
REQ-012 Port buzzer_en  out  1  buzzer enable.
REQ-013 Port snooze_active  out  1  high while snoozing.
REQ-014 Port snooze_cnt  out  3  snoozes used in current alarm event.
REQ-015 Port missed  out  1  sticky flag: last alarm timed out unanswered.
REQ-016 Port state  out  2  current FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, RINGING=1, SNOOZE=2; encoding 3 unreachable, recovers to IDLE next cycle.
REQ-018 IDLE -> RINGING SHALL occur on a rising edge of alarm_match (registered compare with previous sample) while alarm_armed=1; level-high alarm_match SHALL NOT retrigger.
REQ-019 Entry into RINGING from IDLE SHALL clear snooze_cnt to 0 and clear missed.
REQ-020 A cycle counter (0..CLK_HZ-1) and seconds counter SHALL both clear on every state entry; seconds increments when cycle counter wraps.
REQ-021 RINGING -> IDLE on dismiss_btn; RINGING -> SNOOZE on snooze_btn when snooze_cnt < MAX_SNOOZE, incrementing snooze_cnt; snooze_btn with snooze_cnt==MAX_SNOOZE SHALL be ignored.
REQ-022 RINGING -> IDLE with missed<=1 when seconds reaches RING_SECONDS, i.e. exactly RING_SECONDS*CLK_HZ cycles after entry.
REQ-023 SNOOZE -> RINGING when seconds reaches SNOOZE_SECONDS (snooze_cnt retained); SNOOZE -> IDLE on dismiss_btn.
REQ-024 Priority in one cycle: alarm_armed=0 > dismiss_btn > snooze_btn > timeout.
REQ-025 alarm_armed=0 in any state SHALL force IDLE on the next edge; snooze_cnt and missed retained.
REQ-026 All outputs SHALL be registered and reflect the new state in the same cycle the state register updates (one clk after the causing input is sampled).
REQ-027 led_enable=buzzer_en=1 only in RINGING; snooze_active=1 only in SNOOZE.
REQ-028 missed SHALL clear on dismiss_btn in IDLE or on next IDLE->RINGING entry.
REQ-029 Counter widths SHALL be sized via $clog2 of CLK_HZ and max(RING_SECONDS,SNOOZE_SECONDS)+1; no overflow possible.

Reset
REQ-030 On rst: state=IDLE, all counters 0, led_enable=buzzer_en=snooze_active=0, snooze_cnt=0, missed=0, alarm_match edge register=0.
REQ-031 rst asserted mid-RINGING or mid-SNOOZE SHALL drop led_enable/buzzer_en immediately (asynchronously).
REQ-032 After rst release with alarm_match already high, an edge SHALL be detected on the first sampled cycle (previous sample is 0).

Structure
REQ-033 State encodings and default timing constants SHALL live in shared package alarm_pkg.
REQ-034 The cycle/second counter with synchronous clear SHALL be sub-module sec_tick_gen (outputs tick pulse and seconds count).

Verification (CLK_HZ=10, RING_SECONDS=4, SNOOZE_SECONDS=3, MAX_SNOOZE=2)
REQ-035 armed=1, alarm_match rises at cycle 5 -> state=RINGING, led_enable=1 at cycle 6; no action -> IDLE, missed=1, led_enable=0 at cycle 46.
REQ-036 RINGING, snooze_btn -> SNOOZE, snooze_cnt=1 next cycle; 30 cycles later RINGING again, led_enable=1.
REQ-037 Snooze twice, third snooze_btn in RINGING -> ignored, stays RINGING, snooze_cnt=2.
REQ-038 snooze_btn and dismiss_btn same cycle in RINGING -> IDLE, snooze_cnt unchanged.
REQ-039 alarm_match held high 100 cycles after dismiss -> stays IDLE; alarm_armed=0 during SNOOZE -> IDLE next cycle.
REQ-040 rst pulse mid-RINGING -> led_enable=0 before next clk edge; all outputs at reset values.
